// File: rtl/bicubic_pkg.sv
// Shared defaults and FSM encoding for the bicubic tap fetcher.
package bicubic_pkg;

    localparam int FBIT_DEF = 15;
    localparam int AW_DEF   = 7;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_OUT   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Fetch phase counter: issues reads on 1..3 (index 0 is issued on entry), captures on 2..5.
    localparam logic [2:0] FETCH_LAST_ISSUE = 3'd3;
    localparam logic [2:0] FETCH_LAST       = 3'd5;

endpackage

// File: rtl/bicubic_addr_clamp.sv
// Clamps a two's-complement source index into [0, lim_w-1].
module bicubic_addr_clamp
    import bicubic_pkg::*;
#(
    parameter int AW = AW_DEF
) (
    input  logic [AW+1:0] idx,
    input  logic [AW:0]   lim_w,
    output logic [AW-1:0] addr
);

    logic [AW:0] w_max;

    assign w_max = lim_w - (AW+1)'(1);

    always_comb begin
        addr = idx[AW-1:0];
        if (idx[AW+1]) begin
            addr = '0;
        end else if (idx[AW:0] > w_max) begin
            addr = w_max[AW-1:0];
        end
    end

endmodule

// File: rtl/bicubic_tap_fetcher.sv
// Walks a source row at a fixed fractional step and presents four clamped
// neighbour taps plus the fractional position for each output pixel.
module bicubic_tap_fetcher
    import bicubic_pkg::*;
#(
    parameter int FBIT = FBIT_DEF,
    parameter int AW   = AW_DEF
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               start,
    input  logic [AW:0]        in_w,
    input  logic [AW:0]        out_w,
    input  logic [AW+FBIT-1:0] step,
    output logic               rd_en,
    output logic [AW-1:0]      rd_addr,
    input  logic [7:0]         rd_data,
    output logic [7:0]         ipn,
    output logic [7:0]         ip0,
    output logic [7:0]         ip1,
    output logic [7:0]         ip2,
    output logic [FBIT-1:0]    x,
    output logic               tap_valid,
    input  logic               tap_ready,
    output logic               busy,
    output logic               done,
    output state_t             dbg_state
);

    // Handshake: a tap set transfers on a rising edge where tap_valid && tap_ready;
    // taps and x hold while tap_valid && !tap_ready.
    state_t             r_state;
    logic [AW:0]        r_in_w;
    logic [AW:0]        r_out_w;
    logic [AW+FBIT-1:0] r_step;
    logic [AW+FBIT-1:0] r_pos;
    logic [AW:0]        r_k;
    logic [2:0]         r_fcnt;
    logic               r_rd_en;
    logic [AW-1:0]      r_rd_addr;
    logic [7:0]         r_ipn, r_ip0, r_ip1, r_ip2;
    logic [FBIT-1:0]    r_x;
    logic               r_tap_valid;
    logic               r_busy;
    logic               r_done;

    logic               w_hs;
    logic               w_last;
    logic               w_next_last;
    logic [AW+FBIT-1:0] w_pos_end;
    logic [AW+FBIT-1:0] w_pos_next;
    logic [AW-1:0]      w_i_cur;
    logic [AW-1:0]      w_i_next;
    logic [AW-1:0]      w_base;
    logic [AW+1:0]      w_off;
    logic [AW+1:0]      w_idx;
    logic [AW:0]        w_clamp_w;
    logic [AW-1:0]      w_addr;

    assign w_hs        = (r_state == S_OUT) && r_tap_valid && tap_ready;
    assign w_last      = (r_k == (r_out_w - (AW+1)'(1)));
    assign w_next_last = ((r_k + (AW+1)'(1)) == (r_out_w - (AW+1)'(1)));
    // The final output lands exactly on the last source pixel, whatever step rounding left.
    assign w_pos_end   = (AW+FBIT)'(r_in_w - (AW+1)'(1)) << FBIT;
    assign w_pos_next  = w_next_last ? w_pos_end : (r_pos + r_step);
    assign w_i_cur     = r_pos[AW+FBIT-1:FBIT];
    assign w_i_next    = w_pos_next[AW+FBIT-1:FBIT];

    // On entry to FETCH the first address (i-1) is issued from the incoming position.
    always_comb begin
        w_base = '0;
        if (r_state == S_FETCH) begin
            w_base = w_i_cur;
        end else if (r_state == S_OUT) begin
            w_base = w_i_next;
        end
    end

    assign w_off     = (r_state == S_FETCH) ? ((AW+2)'(r_fcnt) - (AW+2)'(1)) : '1;
    assign w_idx     = {2'b00, w_base} + w_off;
    assign w_clamp_w = (r_state == S_IDLE) ? in_w : r_in_w;

    bicubic_addr_clamp #(.AW(AW)) u_clamp (
        .idx   (w_idx),
        .lim_w (w_clamp_w),
        .addr  (w_addr)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= S_IDLE;
            r_in_w      <= '0;
            r_out_w     <= '0;
            r_step      <= '0;
            r_pos       <= '0;
            r_k         <= '0;
            r_fcnt      <= '0;
            r_rd_en     <= 1'b0;
            r_rd_addr   <= '0;
            r_ipn       <= '0;
            r_ip0       <= '0;
            r_ip1       <= '0;
            r_ip2       <= '0;
            r_x         <= '0;
            r_tap_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_in_w    <= in_w;
                        r_out_w   <= out_w;
                        r_step    <= step;
                        r_pos     <= '0;
                        r_k       <= '0;
                        r_x       <= '0;
                        r_busy    <= 1'b1;
                        r_rd_en   <= 1'b1;
                        r_rd_addr <= w_addr;
                        r_fcnt    <= 3'd1;
                        r_state   <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (r_fcnt <= FETCH_LAST_ISSUE) begin
                        r_rd_en   <= 1'b1;
                        r_rd_addr <= w_addr;
                    end else begin
                        r_rd_en   <= 1'b0;
                    end
                    case (r_fcnt)
                        3'd2:    r_ipn <= rd_data;
                        3'd3:    r_ip0 <= rd_data;
                        3'd4:    r_ip1 <= rd_data;
                        3'd5:    r_ip2 <= rd_data;
                        default: ;
                    endcase
                    if (r_fcnt == FETCH_LAST) begin
                        r_tap_valid <= 1'b1;
                        r_state     <= S_OUT;
                    end else begin
                        r_fcnt <= r_fcnt + 3'd1;
                    end
                end
                S_OUT: begin
                    if (w_hs) begin
                        r_tap_valid <= 1'b0;
                        if (w_last) begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_k   <= r_k + (AW+1)'(1);
                            r_pos <= w_pos_next;
                            r_x   <= w_pos_next[FBIT-1:0];
                            if (w_i_next != w_i_cur) begin
                                r_rd_en   <= 1'b1;
                                r_rd_addr <= w_addr;
                                r_fcnt    <= 3'd1;
                                r_state   <= S_FETCH;
                            end
                        end
                    end else if (!r_tap_valid) begin
                        r_tap_valid <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign rd_en     = r_rd_en;
    assign rd_addr   = r_rd_addr;
    assign ipn       = r_ipn;
    assign ip0       = r_ip0;
    assign ip1       = r_ip1;
    assign ip2       = r_ip2;
    assign x         = r_x;
    assign tap_valid = r_tap_valid;
    assign busy      = r_busy;
    assign done      = r_done;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_bicubic_tap_fetcher.sv
// Bench for bicubic_tap_fetcher: row-level reference model, per-cycle compare, directed rows.
module tb_bicubic_tap_fetcher;
  import bicubic_pkg::*;

  localparam int FBIT = 15;
  localparam int AW   = 7;
  localparam int W    = 4 * 8 + FBIT;

  // clock / reset
  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  logic               start = 1'b0;
  logic [AW:0]        in_w = '0;
  logic [AW:0]        out_w = '0;
  logic [AW+FBIT-1:0] step = '0;
  logic               rd_en;
  logic [AW-1:0]      rd_addr;
  logic [7:0]         rd_data = '0;
  logic [7:0]         ipn, ip0, ip1, ip2;
  logic [FBIT-1:0]    x;
  logic               tap_valid;
  logic               tap_ready = 1'b1;
  logic               busy, done;
  state_t             dbg_state;

  bicubic_tap_fetcher #(.FBIT(FBIT), .AW(AW)) dut (
    .CLK(CLK), .RST(RST), .start(start), .in_w(in_w), .out_w(out_w), .step(step),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .ipn(ipn), .ip0(ip0), .ip1(ip1), .ip2(ip2), .x(x),
    .tap_valid(tap_valid), .tap_ready(tap_ready),
    .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  // source memory: data valid the cycle after rd_en
  logic [7:0] mem [0:(1<<AW)-1];
  always @(posedge CLK) if (rd_en) rd_data <= mem[rd_addr];

  // scoreboard
  logic [W-1:0]  exp_q[$];
  logic [AW-1:0] exp_addr[$];
  int n_cmp = 0;
  int n_fail = 0;
  int rd_cnt = 0;
  int acc = 0;
  int stall_seen = 0;
  int stall_k = -1;
  int stall_left = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int clampi(input int v, input int w);
    if (v < 0) return 0;
    if (v > w - 1) return w - 1;
    return v;
  endfunction

  // Reference: every output position from k*step (last one pinned to in_w-1),
  // taps from clamped neighbours, a 4-read fetch whenever the integer index moves.
  task automatic build_row(input int iw, input int ow, input int st, output int nf);
    longint p;
    int i, xv, prev_i;
    int a[4];
    nf = 0;
    prev_i = -1;
    for (int k = 0; k < ow; k++) begin
      p  = (k == ow - 1) ? (longint'(iw - 1) << FBIT) : longint'(k) * longint'(st);
      i  = int'(p >> FBIT);
      xv = int'(p % (longint'(1) << FBIT));
      for (int j = 0; j < 4; j++) a[j] = clampi(i - 1 + j, iw);
      if (i != prev_i) begin
        nf++;
        for (int j = 0; j < 4; j++) exp_addr.push_back(AW'(a[j]));
      end
      prev_i = i;
      exp_q.push_back({mem[a[0]], mem[a[1]], mem[a[2]], mem[a[3]], FBIT'(xv)});
    end
  endtask

  // compare process
  always @(negedge CLK) begin
    if (!RST) begin
      if (rd_en) begin
        rd_cnt++;
        if (exp_addr.size() == 0) chk("rd_en_unexpected", 64'(rd_en), 64'(0));
        else begin
          chk("rd_addr", 64'(rd_addr), 64'(exp_addr[0]));
          void'(exp_addr.pop_front());
        end
      end
      if (tap_valid) begin
        if (exp_q.size() == 0) chk("tap_valid_unexpected", 64'(tap_valid), 64'(0));
        else begin
          chk("taps_x", 64'({ipn, ip0, ip1, ip2, x}), 64'(exp_q[0]));
          if (tap_ready) begin
            void'(exp_q.pop_front());
            acc++;
          end else stall_seen++;
        end
      end
    end
  end

  // consumer ready driver
  initial begin
    forever begin
      @(posedge CLK);
      #2;
      if (tap_valid && acc == stall_k && stall_left > 0) begin
        tap_ready = 1'b0;
        stall_left--;
      end else tap_ready = 1'b1;
    end
  end

  task automatic check_idle_zero(input string tag);
    chk({tag, "_rd_en"}, 64'(rd_en), 0);
    chk({tag, "_rd_addr"}, 64'(rd_addr), 0);
    chk({tag, "_taps"}, 64'({ipn, ip0, ip1, ip2}), 0);
    chk({tag, "_x"}, 64'(x), 0);
    chk({tag, "_tap_valid"}, 64'(tap_valid), 0);
    chk({tag, "_busy"}, 64'(busy), 0);
    chk({tag, "_done"}, 64'(done), 0);
    chk({tag, "_state"}, 64'(dbg_state), 64'(S_IDLE));
  endtask

  task automatic run_row(input int iw, input int ow, input int st, input int inject_at,
                         input bit start_on_done, input string tag);
    int nf, cyc, first_v, budget;
    bit seen_done;
    build_row(iw, ow, st, nf);
    rd_cnt = 0;
    acc = 0;
    @(posedge CLK); #1;
    in_w = (AW+1)'(iw); out_w = (AW+1)'(ow); step = (AW+FBIT)'(st); start = 1'b1;
    cyc = -1; first_v = -1; seen_done = 1'b0; budget = 20 * ow + 40;
    while (!seen_done && cyc < budget) begin
      @(posedge CLK); #1;
      start = 1'b0;
      cyc++;
      if (tap_valid && first_v < 0) first_v = cyc;
      if (cyc == inject_at) begin
        in_w = 3; out_w = 2; step = 0; start = 1'b1;
      end
      if (done) seen_done = 1'b1;
    end
    chk({tag, "_done_seen"}, 64'(seen_done), 1);
    chk({tag, "_first_valid_edge"}, 64'(first_v), 5);
    chk({tag, "_busy_at_done"}, 64'(busy), 1);
    chk({tag, "_sets_left"}, 64'(exp_q.size()), 0);
    chk({tag, "_addrs_left"}, 64'(exp_addr.size()), 0);
    chk({tag, "_rd_count"}, 64'(rd_cnt), 64'(4 * nf));
    chk({tag, "_accepted"}, 64'(acc), 64'(ow));
    if (start_on_done) begin
      in_w = 4; out_w = 4; step = 32768; start = 1'b1;
    end
    @(posedge CLK); #1;
    start = 1'b0;
    chk({tag, "_done_pulse_end"}, 64'(done), 0);
    chk({tag, "_busy_end"}, 64'(busy), 0);
    chk({tag, "_state_end"}, 64'(dbg_state), 64'(S_IDLE));
    if (start_on_done) begin
      repeat (3) @(posedge CLK);
      #1;
      chk({tag, "_no_restart_busy"}, 64'(busy), 0);
      chk({tag, "_no_restart_rd"}, 64'(rd_en), 0);
    end
    exp_q.delete();
    exp_addr.delete();
  endtask

  task automatic fill_random();
    for (int j = 0; j < (1 << AW); j++) mem[j] = 8'($urandom_range(1, 255));
  endtask

  task automatic reset_mid_fetch();
    int nf, n, cyc;
    build_row(6, 4, 54613, nf);
    @(posedge CLK); #1;
    in_w = 6; out_w = 4; step = 54613; start = 1'b1;
    n = 0; cyc = 0;
    while (n < 2 && cyc < 20) begin
      @(posedge CLK); #1;
      start = 1'b0;
      cyc++;
      if (rd_en) n++;
    end
    chk("rst_second_rd_en_seen", 64'(n), 2);
    RST = 1'b1;
    @(posedge CLK); #1;
    check_idle_zero("rst_mid");
    exp_q.delete();
    exp_addr.delete();
    RST = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_no_done", 64'(done), 0);
  endtask

  initial begin
    int nf;
    fill_random();
    repeat (3) @(posedge CLK);
    #1;
    check_idle_zero("reset");
    RST = 1'b0;

    // upscale 4 -> 7; pin the model against hand-computed sets first
    mem[0] = 8'd10; mem[1] = 8'd20; mem[2] = 8'd30; mem[3] = 8'd40;
    build_row(4, 7, 16384, nf);
    chk("model_k0", 64'(exp_q[0]), 64'({8'd10, 8'd10, 8'd20, 8'd30, 15'd0}));
    chk("model_k1", 64'(exp_q[1]), 64'({8'd10, 8'd10, 8'd20, 8'd30, 15'd16384}));
    chk("model_k6", 64'(exp_q[6]), 64'({8'd30, 8'd40, 8'd40, 8'd40, 15'd0}));
    chk("model_fetches", 64'(nf), 4);
    exp_q.delete();
    exp_addr.delete();
    stall_seen = 0;
    run_row(4, 7, 16384, -1, 1'b0, "up4to7");
    chk("up4to7_no_stall", 64'(stall_seen), 0);

    // same row, consumer stalls 3 cycles on k1
    stall_seen = 0; stall_k = 1; stall_left = 3;
    run_row(4, 7, 16384, -1, 1'b0, "stall_k1");
    chk("stall_k1_cycles", 64'(stall_seen), 3);
    stall_k = -1;

    // identity 8 -> 8 with a stray start mid-row and one coincident with done
    fill_random();
    run_row(8, 8, 32768, 10, 1'b1, "id8");

    // reset during the second read of a fetch, then a full row
    reset_mid_fetch();
    run_row(5, 9, 16384, -1, 1'b0, "after_rst");

    // downscale and full-width endpoints
    run_row(16, 5, 122880, -1, 1'b0, "down16to5");
    run_row(128, 2, 4161536, -1, 1'b0, "w128to2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
